mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between the instruction-fetch path and the

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and
// the load/store data path. One access in flight at a time, round-robin on ties.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // load/store data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter only has to hold MEM_LAT-1.
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic OwnerIf   = 1'b0;
    localparam logic OwnerData = 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_owner_q, last_owner_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            pick_data;

    // State and captured-request registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_owner_q <= OwnerData;  // fetch wins the first tie
            owner_q      <= OwnerIf;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Arbitration, issue/wait sequencing and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pick_data    = 1'b0;

        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    // On a tie, the port that did not own the last access wins.
                    pick_data = d_req && (!if_req || (last_owner_q == OwnerIf));
                    if (pick_data) begin
                        d_gnt   = 1'b1;
                        owner_d = OwnerData;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        if_gnt  = 1'b1;
                        owner_d = OwnerIf;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                    last_owner_d = pick_data ? OwnerData : OwnerIf;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cnt_d     = CW'(MEM_LAT - 1);
                state_d   = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (owner_q == OwnerData) begin
                        d_rvalid = 1'b1;
                        d_rdata  = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance (dut) and MEM_LAT=1
// instance (dut1). Inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    // MEM_LAT = 2 instance signals
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT = 1 instance signals
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        mem_rdata = 32'hFFFF_FFFF;
        sample();
        checks++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got if_rv=%b d_rv=%b mem_en=%b expected all 0",
                     if_rvalid, d_rvalid, mem_en);
        end
        next_cycle();
        reset = 1'b0;
        mem_rdata = '0;
    endtask

    // Lone fetch at T with MEM_LAT=2.
    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h4;
        sample();
        checks++;
        if ({if_gnt, d_gnt, mem_en} !== 3'b100) begin
            errors++; $display("FAIL fetch_gnt: got %b expected 100", {if_gnt, d_gnt, mem_en});
        end
        next_cycle();                         // T+1
        if_req = 1'b0; if_addr = 32'hFFFF_FFF0;
        sample();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h4, 32'h0}) begin
            errors++;
            $display("FAIL fetch_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=4",
                     mem_en, mem_we, mem_addr);
        end
        next_cycle();                         // T+2
        sample();
        checks++;
        if ({mem_en, if_rvalid, if_gnt} !== 3'b000) begin
            errors++; $display("FAIL fetch_wait: got %b expected 000", {mem_en, if_rvalid, if_gnt});
        end
        next_cycle();                         // T+3
        mem_rdata = 32'h0050_0093;
        sample();
        checks++;
        if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h0050_0093, 1'b0}) begin
            errors++;
            $display("FAIL fetch_rvalid: got rv=%b data=%h d_rv=%b expected rv=1 data=00500093",
                     if_rvalid, if_rdata, d_rvalid);
        end
        next_cycle();                         // T+4
        sample();
        checks++;
        if ({if_rvalid, if_rdata} !== '0) begin
            errors++; $display("FAIL fetch_rdata_clear: got rv=%b data=%h expected 0",
                               if_rvalid, if_rdata);
        end
        mem_rdata = '0;
    endtask

    // Both ports held high from reset: grants alternate every 4 cycles.
    task automatic test_round_robin();
        logic exp_ig, exp_dg, exp_ir, exp_dr;
        test_reset();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
        for (int k = 0; k < 16; k++) begin
            mem_rdata = 32'h1000 + k;
            exp_ig = (k % 8 == 0);
            exp_dg = (k % 8 == 4);
            exp_ir = (k % 8 == 3);
            exp_dr = (k % 8 == 7);
            sample();
            checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== {exp_ig, exp_dg, exp_ir, exp_dr}) begin
                errors++;
                $display("FAIL rr_cycle%0d: got ig/dg/ir/dr=%b expected %b", k,
                         {if_gnt, d_gnt, if_rvalid, d_rvalid}, {exp_ig, exp_dg, exp_ir, exp_dr});
            end
            if (exp_ir || exp_dr) begin
                checks++;
                if ((exp_ir ? if_rdata : d_rdata) !== 32'h1000 + k) begin
                    errors++;
                    $display("FAIL rr_rdata%0d: got %h expected %h", k,
                             exp_ir ? if_rdata : d_rdata, 32'h1000 + k);
                end
            end
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0; mem_rdata = '0;
    endtask

    // Store: write strobe carries captured data, completion pulse has zero data.
    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        sample();
        checks++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL store_gnt: got %b expected 10", {d_gnt, if_gnt});
        end
        next_cycle();                         // T+1
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        sample();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h expected 1 1 10 deadbeef",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();                         // T+2
        next_cycle();                         // T+3
        mem_rdata = 32'h1234_5678;
        sample();
        checks++;
        if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_done: got d_rv=%b d_rdata=%h if_rv=%b expected 1 0 0",
                     d_rvalid, d_rdata, if_rvalid);
        end
        next_cycle();                         // T+4
        mem_rdata = '0;
    endtask

    // Fetch request arriving while a data access is in flight waits for IDLE.
    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        sample();
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL b2b_dgnt: got %b expected 1", d_gnt);
        end
        next_cycle();                         // T+1
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        for (int k = 1; k <= 3; k++) begin
            mem_rdata = (k == 3) ? 32'hA5A5_0001 : 32'h0;
            sample();
            checks++;
            if (if_gnt !== 1'b0) begin
                errors++; $display("FAIL b2b_hold%0d: got if_gnt=%b expected 0", k, if_gnt);
            end
            if (k == 3) begin
                checks++;
                if ({d_rvalid, d_rdata} !== {1'b1, 32'hA5A5_0001}) begin
                    errors++; $display("FAIL b2b_drdata: got rv=%b data=%h expected 1 a5a50001",
                                       d_rvalid, d_rdata);
                end
            end
            next_cycle();
        end
        mem_rdata = '0;                       // T+4
        sample();
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL b2b_if_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();                         // T+5
        if_req = 1'b0;
        next_cycle();                         // T+6
        next_cycle();                         // T+7
        mem_rdata = 32'h0000_0BAD;
        sample();
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000_0BAD}) begin
            errors++; $display("FAIL b2b_if_rdata: got rv=%b data=%h expected 1 00000bad",
                               if_rvalid, if_rdata);
        end
        next_cycle();
        mem_rdata = '0;
    endtask

    // Reset while a fetch waits on memory: no completion, fresh arbitration.
    task automatic test_reset_midflight();
        if_req = 1'b1; if_addr = 32'h20;
        sample();
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++; $display("FAIL midrst_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();                         // T+1
        if_req = 1'b0;
        next_cycle();                         // T+2
        reset = 1'b1;
        next_cycle();                         // T+3
        reset = 1'b0;
        mem_rdata = 32'h7777_7777;
        sample();
        checks++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got if_rv=%b if_rdata=%h mem_en=%b expected all 0",
                     if_rvalid, if_rdata, mem_en);
        end
        next_cycle();                         // T+4
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h24; d_addr = 32'h28;
        sample();
        checks++;
        if ({if_gnt, d_gnt, if_rvalid} !== 3'b100) begin
            errors++; $display("FAIL midrst_regrant: got ig/dg/ir=%b expected 100",
                               {if_gnt, d_gnt, if_rvalid});
        end
        next_cycle();                         // T+5
        if_req = 1'b0; d_req = 1'b0; mem_rdata = '0;
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    // MEM_LAT=1 instance: data valid one cycle after the strobe.
    task automatic test_lat1();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h8;
        sample();
        checks++;
        if (b_d_gnt !== 1'b1) begin
            errors++; $display("FAIL lat1_gnt: got %b expected 1", b_d_gnt);
        end
        next_cycle();                         // T+1
        b_d_req = 1'b0;
        sample();
        checks++;
        if ({b_mem_en, b_mem_we, b_mem_addr, b_d_rvalid} !== {1'b1, 1'b0, 32'h8, 1'b0}) begin
            errors++; $display("FAIL lat1_issue: got en=%b we=%b addr=%h rv=%b expected 1 0 8 0",
                               b_mem_en, b_mem_we, b_mem_addr, b_d_rvalid);
        end
        next_cycle();                         // T+2
        b_d_req = 1'b1; b_d_addr = 32'hC;
        b_mem_rdata = 32'hCAFE_F00D;
        sample();
        checks++;
        if ({b_d_rvalid, b_d_rdata, b_d_gnt} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            errors++; $display("FAIL lat1_rvalid: got rv=%b data=%h gnt=%b expected 1 cafef00d 0",
                               b_d_rvalid, b_d_rdata, b_d_gnt);
        end
        next_cycle();                         // T+3
        b_mem_rdata = '0;
        sample();
        checks++;
        if ({b_d_gnt, b_d_rvalid} !== 2'b10) begin
            errors++; $display("FAIL lat1_regrant: got gnt/rv=%b expected 10", {b_d_gnt, b_d_rvalid});
        end
        next_cycle();
        b_d_req = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        b_mem_rdata = '0;
        #1;
        test_reset();
        test_fetch();
        test_round_robin();
        test_store();
        test_back_to_back();
        test_reset_midflight();
        test_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
